snapshot_reg_ctrl: RTL and testbench



---
 rtl/snapshot_reg_ctrl.sv | 159 +++++++++++++++
 tb/tb_snapshot_reg_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_reg_ctrl.sv
// Snapshot front-end for one wide register: atomic capture on the trigger partition,
// staged writes committed atomically on the commit partition, with sequence tracking.
//
// state    | meaning
// S_IDLE   | no partition sequence open
// S_RD_SEQ | snapshot captured, remaining partitions being read
// S_WR_SEQ | partitions being staged, waiting for the commit partition
module snapshot_reg_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_WIDTH      = 128,
  parameter int PARTITION_CNT  = REG_WIDTH / DATA_WIDTH,
  parameter int ACCESS_ORDER   = 0,
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [REG_WIDTH-1:0] RST_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     soft_rst,
  input  logic [PARTITION_CNT-1:0] snap_rd_en,
  input  logic [PARTITION_CNT-1:0] snap_wr_en,
  input  logic [DATA_WIDTH-1:0]    snap_wr_data,
  output logic [DATA_WIDTH-1:0]    snap_rd_data,
  output logic                     reg_rd_en,
  input  logic [REG_WIDTH-1:0]     reg_rd_data,
  output logic                     reg_wr_en,
  output logic [REG_WIDTH-1:0]     reg_wr_data,
  output logic                     snap_busy,
  output logic                     err_seq,
  output logic                     err_timeout
);

  localparam int TC    = (ACCESS_ORDER == 0) ? 0 : PARTITION_CNT - 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [PARTITION_CNT-1:0] TC_MASK  = PARTITION_CNT'(1) << TC;
  localparam logic [PARTITION_CNT-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RD_SEQ, S_WR_SEQ} state_t;

  state_t                   state_q, state_d;
  logic [REG_WIDTH-1:0]     snapshot_q, snapshot_d;
  logic [PARTITION_CNT-1:0] rd_mask_q, rd_mask_d, wr_mask_q, wr_mask_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_seq_d, err_timeout_d;
  logic                     illegal, is_rd, is_wr;
  logic [2*PARTITION_CNT-1:0] acc_vec;

  assign acc_vec = {snap_wr_en, snap_rd_en};
  assign illegal = $countones(acc_vec) > 1;
  assign is_rd   = ($countones(acc_vec) == 1) && (|snap_rd_en);
  assign is_wr   = ($countones(acc_vec) == 1) && (|snap_wr_en);

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q     <= S_IDLE;
      snapshot_q  <= RST_VALUE;
      rd_mask_q   <= '0;
      wr_mask_q   <= '0;
      cnt_q       <= '0;
      snap_busy   <= 1'b0;
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      snapshot_q  <= snapshot_d;
      rd_mask_q   <= rd_mask_d;
      wr_mask_q   <= wr_mask_d;
      cnt_q       <= cnt_d;
      snap_busy   <= (state_d != S_IDLE);
      err_seq     <= err_seq_d;
      err_timeout <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    snapshot_d    = snapshot_q;
    rd_mask_d     = rd_mask_q;
    wr_mask_d     = wr_mask_q;
    cnt_d         = cnt_q;
    err_seq_d     = 1'b0;
    err_timeout_d = 1'b0;
    snap_rd_data  = '0;
    reg_rd_en     = 1'b0;
    reg_wr_en     = 1'b0;
    reg_wr_data   = snapshot_q;
    reg_wr_data[TC*DATA_WIDTH +: DATA_WIDTH] = snap_wr_data;

    if (illegal) begin
      err_seq_d = 1'b1;
    end else if (is_rd) begin
      cnt_d = '0;
      for (int p = 0; p < PARTITION_CNT; p++) begin
        if (snap_rd_en[p]) begin
          if (p == TC) begin
            reg_rd_en    = 1'b1;
            snap_rd_data = reg_rd_data[p*DATA_WIDTH +: DATA_WIDTH];
            snapshot_d   = reg_rd_data;
            rd_mask_d    = TC_MASK;
            wr_mask_d    = '0;
            state_d      = (TC_MASK == ALL_ONES) ? S_IDLE : S_RD_SEQ;
            err_seq_d    = (state_q == S_WR_SEQ) ||
                           ((state_q == S_RD_SEQ) && (rd_mask_q != ALL_ONES));
          end else begin
            snap_rd_data = snapshot_q[p*DATA_WIDTH +: DATA_WIDTH];
            if (state_q == S_RD_SEQ) begin
              rd_mask_d = rd_mask_q | (PARTITION_CNT'(1) << p);
              if (rd_mask_d == ALL_ONES) state_d = S_IDLE;
            end else begin
              // Non-trigger read without a capture returns stale data and drops the sequence
              err_seq_d = 1'b1;
              state_d   = S_IDLE;
              rd_mask_d = '0;
              wr_mask_d = '0;
            end
          end
        end
      end
    end else if (is_wr) begin
      cnt_d = '0;
      for (int p = 0; p < PARTITION_CNT; p++) begin
        if (snap_wr_en[p]) begin
          snapshot_d[p*DATA_WIDTH +: DATA_WIDTH] = snap_wr_data;
          if (p == TC) begin
            reg_wr_en = 1'b1;
            err_seq_d = ((wr_mask_q | TC_MASK) != ALL_ONES);
            rd_mask_d = '0;
            wr_mask_d = '0;
            state_d   = S_IDLE;
          end else begin
            wr_mask_d = wr_mask_q | (PARTITION_CNT'(1) << p);
            state_d   = S_WR_SEQ;
            if (state_q == S_RD_SEQ) begin
              rd_mask_d = '0;
              err_seq_d = 1'b1;
            end
          end
        end
      end
    end else if ((TIMEOUT_CYCLES > 0) && (state_q != S_IDLE)) begin
      if (cnt_q == TO_LAST) begin
        state_d       = S_IDLE;
        rd_mask_d     = '0;
        wr_mask_d     = '0;
        err_timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (state_d == S_IDLE) cnt_d = '0;

    if (soft_rst) begin
      snap_rd_data = '0;
      reg_rd_en    = 1'b0;
      reg_wr_en    = 1'b0;
    end
  end

endmodule

// File: tb/tb_snapshot_reg_ctrl.sv
// Directed bench for snapshot_reg_ctrl: vector tables for read/write sequences plus
// hand-written sequences for timeout, reset and single-partition corners.
module tb_snapshot_reg_ctrl;

  localparam logic [127:0] A = 128'h00004444_00003333_00002222_00001111;
  localparam logic [127:0] B = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;

  logic         clk = 1'b0;
  logic         soft_rst;
  logic [3:0]   rd_en, wr_en;
  logic [31:0]  wr_data;
  logic [127:0] rrd;
  logic         rd1, wr1;
  logic [31:0]  rrd1;

  logic [31:0]  rdata0, rdata1, rdata2, rdata3;
  logic         rren0, rren1, rren2, rren3;
  logic         wen0, wen1, wen2, wen3;
  logic [127:0] wdata0, wdata1, wdata2;
  logic [31:0]  wdata3;
  logic         busy0, busy1, busy2, busy3;
  logic         es0, es1, es2, es3;
  logic         et0, et1, et2, et3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  snapshot_reg_ctrl #(.ACCESS_ORDER(0), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .soft_rst(soft_rst), .snap_rd_en(rd_en), .snap_wr_en(wr_en),
    .snap_wr_data(wr_data), .snap_rd_data(rdata0), .reg_rd_en(rren0), .reg_rd_data(rrd),
    .reg_wr_en(wen0), .reg_wr_data(wdata0), .snap_busy(busy0), .err_seq(es0),
    .err_timeout(et0));

  snapshot_reg_ctrl #(.ACCESS_ORDER(1), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .soft_rst(soft_rst), .snap_rd_en(rd_en), .snap_wr_en(wr_en),
    .snap_wr_data(wr_data), .snap_rd_data(rdata1), .reg_rd_en(rren1), .reg_rd_data(rrd),
    .reg_wr_en(wen1), .reg_wr_data(wdata1), .snap_busy(busy1), .err_seq(es1),
    .err_timeout(et1));

  snapshot_reg_ctrl #(.ACCESS_ORDER(0), .TIMEOUT_CYCLES(4)) dut2 (
    .clk(clk), .soft_rst(soft_rst), .snap_rd_en(rd_en), .snap_wr_en(wr_en),
    .snap_wr_data(wr_data), .snap_rd_data(rdata2), .reg_rd_en(rren2), .reg_rd_data(rrd),
    .reg_wr_en(wen2), .reg_wr_data(wdata2), .snap_busy(busy2), .err_seq(es2),
    .err_timeout(et2));

  snapshot_reg_ctrl #(.DATA_WIDTH(32), .REG_WIDTH(32)) dut3 (
    .clk(clk), .soft_rst(soft_rst), .snap_rd_en(rd1), .snap_wr_en(wr1),
    .snap_wr_data(wr_data), .snap_rd_data(rdata3), .reg_rd_en(rren3), .reg_rd_data(rrd1),
    .reg_wr_en(wen3), .reg_wr_data(wdata3), .snap_busy(busy3), .err_seq(es3),
    .err_timeout(et3));

  typedef struct {
    logic [3:0]   rd;
    logic [3:0]   wr;
    logic [31:0]  wd;
    logic [127:0] rrd;
    logic [31:0]  e_rdata;
    logic         e_rren;
    logic         e_wen;
    logic [127:0] e_wdata;
    logic         e_busy;
    logic         e_err;
  } vec_t;

  vec_t tbl0[22];
  vec_t tbl1[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en = '0; wr_en = '0; wr_data = '0; rd1 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic do_reset();
    soft_rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 soft_rst = 1'b0;
  endtask

  // Called at posedge+1; comb outputs checked at negedge, registered ones after the edge.
  task automatic run_vec(input vec_t v, input int which, input string tag);
    logic [31:0]  rdata;
    logic         rren, wen, busy, es;
    logic [127:0] wdata;
    rd_en = v.rd; wr_en = v.wr; wr_data = v.wd; rrd = v.rrd;
    @(negedge clk);
    if (which == 0) begin rdata = rdata0; rren = rren0; wen = wen0; wdata = wdata0; end
    else            begin rdata = rdata1; rren = rren1; wen = wen1; wdata = wdata1; end
    chk({tag, " rd_data"}, 128'(rdata), 128'(v.e_rdata));
    chk({tag, " reg_rd_en"}, 128'(rren), 128'(v.e_rren));
    chk({tag, " reg_wr_en"}, 128'(wen), 128'(v.e_wen));
    if (v.e_wen) chk({tag, " reg_wr_data"}, wdata, v.e_wdata);
    @(posedge clk);
    #1;
    if (which == 0) begin busy = busy0; es = es0; end
    else            begin busy = busy1; es = es1; end
    chk({tag, " snap_busy"}, 128'(busy), 128'(v.e_busy));
    chk({tag, " err_seq"}, 128'(es), 128'(v.e_err));
  endtask

  initial begin
    //            rd       wr       wd      rrd  rdata     rren wen wdata                                  busy err
    tbl0[0]  = '{4'b0001, 4'b0000, 32'h0,  A, 32'h1111, 1'b1, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[1]  = '{4'b0010, 4'b0000, 32'h0,  B, 32'h2222, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[2]  = '{4'b0100, 4'b0000, 32'h0,  B, 32'h3333, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[3]  = '{4'b1000, 4'b0000, 32'h0,  B, 32'h4444, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0};
    tbl0[4]  = '{4'b0000, 4'b1000, 32'hD,  B, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[5]  = '{4'b0000, 4'b0100, 32'hC,  B, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[6]  = '{4'b0000, 4'b0010, 32'hB,  B, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[7]  = '{4'b0000, 4'b0001, 32'hA,  B, 32'h0,    1'b0, 1'b1,
                 128'h0000000D_0000000C_0000000B_0000000A, 1'b0, 1'b0};
    tbl0[8]  = '{4'b0000, 4'b1000, 32'h1D, B, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[9]  = '{4'b0000, 4'b0010, 32'h1B, B, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[10] = '{4'b0000, 4'b0001, 32'h1A, B, 32'h0,    1'b0, 1'b1,
                 128'h0000001D_0000000C_0000001B_0000001A, 1'b0, 1'b1};
    tbl0[11] = '{4'b0001, 4'b0000, 32'h0,  A, 32'h1111, 1'b1, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[12] = '{4'b0011, 4'b0000, 32'h0,  A, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b1};
    tbl0[13] = '{4'b0010, 4'b0010, 32'h9,  A, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b1};
    tbl0[14] = '{4'b0010, 4'b0000, 32'h0,  B, 32'h2222, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[15] = '{4'b0100, 4'b0000, 32'h0,  B, 32'h3333, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[16] = '{4'b1000, 4'b0000, 32'h0,  B, 32'h4444, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0};
    tbl0[17] = '{4'b0010, 4'b0000, 32'h0,  B, 32'h2222, 1'b0, 1'b0, 128'h0, 1'b0, 1'b1};
    tbl0[18] = '{4'b0001, 4'b0000, 32'h0,  A, 32'h1111, 1'b1, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl0[19] = '{4'b0000, 4'b0100, 32'h77, A, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b1};
    tbl0[20] = '{4'b0001, 4'b0000, 32'h0,  A, 32'h1111, 1'b1, 1'b0, 128'h0, 1'b1, 1'b1};
    tbl0[21] = '{4'b0000, 4'b0000, 32'h0,  A, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b0};

    // Trigger/commit partition is p3
    tbl1[0]  = '{4'b1000, 4'b0000, 32'h0,  A, 32'h4444, 1'b1, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl1[1]  = '{4'b0100, 4'b0000, 32'h0,  B, 32'h3333, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl1[2]  = '{4'b0010, 4'b0000, 32'h0,  B, 32'h2222, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl1[3]  = '{4'b0001, 4'b0000, 32'h0,  B, 32'h1111, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0};
    tbl1[4]  = '{4'b0001, 4'b0000, 32'h0,  B, 32'h1111, 1'b0, 1'b0, 128'h0, 1'b0, 1'b1};
    tbl1[5]  = '{4'b0000, 4'b0001, 32'h1,  B, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl1[6]  = '{4'b0000, 4'b0010, 32'h2,  B, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl1[7]  = '{4'b0000, 4'b0100, 32'h3,  B, 32'h0,    1'b0, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl1[8]  = '{4'b0000, 4'b1000, 32'h4,  B, 32'h0,    1'b0, 1'b1,
                 128'h00000004_00000003_00000002_00000001, 1'b0, 1'b0};

    rrd = '0; rrd1 = '0;
    do_reset();
    chk("reset busy", 128'(busy0), 128'(0));
    chk("reset err_seq", 128'(es0), 128'(0));
    chk("reset err_timeout", 128'(et0), 128'(0));

    for (int i = 0; i < 22; i++) run_vec(tbl0[i], 0, $sformatf("ord0 v%0d", i));

    do_reset();
    for (int i = 0; i < 9; i++) run_vec(tbl1[i], 1, $sformatf("ord1 v%0d", i));

    // Timeout abort after four idle cycles
    do_reset();
    rd_en = 4'b0001; rrd = A;
    @(posedge clk); #1 idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to busy c%0d", k), 128'(busy2), 128'(1));
      chk($sformatf("to pulse c%0d", k), 128'(et2), 128'(0));
      @(posedge clk); #1;
    end
    chk("to pulse c5", 128'(et2), 128'(1));
    chk("to busy c5", 128'(busy2), 128'(0));
    @(posedge clk); #1;
    chk("to pulse c6", 128'(et2), 128'(0));
    rd_en = 4'b0010; rrd = B;
    @(negedge clk);
    chk("to snapshot kept", 128'(rdata2), 128'(32'h2222));
    @(posedge clk); #1 idle_inputs();
    chk("to stale err_seq", 128'(es2), 128'(1));

    // Access on the terminal cycle cancels the timeout
    do_reset();
    rd_en = 4'b0001; rrd = A;
    @(posedge clk); #1 idle_inputs();
    repeat (3) begin @(posedge clk); #1; end
    rd_en = 4'b0010;
    @(posedge clk); #1 idle_inputs();
    chk("to cancel pulse", 128'(et2), 128'(0));
    chk("to cancel busy", 128'(busy2), 128'(1));

    // Reset mid write sequence discards the staging silently
    do_reset();
    wr_en = 4'b1000; wr_data = 32'h33;
    @(posedge clk); #1 wr_en = 4'b0100; wr_data = 32'h22;
    @(posedge clk); #1 idle_inputs();
    chk("rst busy before", 128'(busy0), 128'(1));
    soft_rst = 1'b1; rd_en = 4'b0001; rrd = A;
    @(negedge clk);
    chk("rst reg_rd_en", 128'(rren0), 128'(0));
    chk("rst rd_data", 128'(rdata0), 128'(0));
    @(posedge clk); #1 soft_rst = 1'b0; idle_inputs();
    chk("rst busy after", 128'(busy0), 128'(0));
    chk("rst err_seq", 128'(es0), 128'(0));
    chk("rst err_timeout", 128'(et0), 128'(0));
    wr_en = 4'b0001; wr_data = 32'h5;
    @(negedge clk);
    chk("rst commit wen", 128'(wen0), 128'(1));
    chk("rst commit data", wdata0, 128'h5);
    @(posedge clk); #1 idle_inputs();
    chk("rst commit err_seq", 128'(es0), 128'(1));
    chk("rst commit busy", 128'(busy0), 128'(0));

    // Single partition: every access is a trigger/commit
    do_reset();
    rd1 = 1'b1; rrd1 = 32'hCAFE0001;
    @(negedge clk);
    chk("p1 reg_rd_en", 128'(rren3), 128'(1));
    chk("p1 rd_data", 128'(rdata3), 128'(32'hCAFE0001));
    @(posedge clk); #1 idle_inputs();
    chk("p1 rd busy", 128'(busy3), 128'(0));
    chk("p1 rd err_seq", 128'(es3), 128'(0));
    wr1 = 1'b1; wr_data = 32'h12345678;
    @(negedge clk);
    chk("p1 wen", 128'(wen3), 128'(1));
    chk("p1 wdata", 128'(wdata3), 128'(32'h12345678));
    @(posedge clk); #1 idle_inputs();
    chk("p1 wr err_seq", 128'(es3), 128'(0));
    chk("p1 wr busy", 128'(busy3), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
